// File: rtl/iter_shifter_pkg.sv
// iter_shifter_pkg: shared definitions for the iterative shifter.
//   - op encodings for the in_op field (3 bits; 101..111 are illegal)
//   - FSM state type
//   - op_legal(): legality check for an op code
package iter_shifter_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ROL = 3'b000;
  localparam logic [OP_W-1:0] OP_ROR = 3'b001;
  localparam logic [OP_W-1:0] OP_SLL = 3'b010;
  localparam logic [OP_W-1:0] OP_SRA = 3'b011;
  localparam logic [OP_W-1:0] OP_SRL = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op <= OP_SRL);
  endfunction

endpackage

// File: rtl/iter_shifter_if.sv
// iter_shifter_if: request/result handshake bundle of the iterative shifter.
//   Request side : in_valid, in_ready, in_data[WIDTH], in_amt[AMT_W], in_op[3]
//   Result side  : out_valid, out_ready, out_data[WIDTH], out_err
//   With ITER_SHIFTER_STATUS_EN defined: out_zero, out_carry (driven by the shifter)
//   Modports: master = requester/consumer (testbench or pipeline), slave = shifter.
interface iter_shifter_if
  import iter_shifter_pkg::*;
#(
  parameter int WIDTH = 16
);
  localparam int AMT_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [OP_W-1:0]  in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
`ifdef ITER_SHIFTER_STATUS_EN
  logic             out_zero;
  logic             out_carry;
`endif

  modport master (
    output in_valid, in_data, in_amt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_err
`ifdef ITER_SHIFTER_STATUS_EN
    , input out_zero, out_carry
`endif
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_err
`ifdef ITER_SHIFTER_STATUS_EN
    , output out_zero, out_carry
`endif
  );

endinterface

// File: rtl/iter_shifter_shift_step.sv
// shift_step: combinational single-step shifter, k = 0..STEP positions.
//   data   : operand
//   op     : op code (illegal codes pass data through, carry 0)
//   k      : positions to shift this step
//   sign   : fill bit for sra (original MSB of the request)
//   result : shifted operand
//   carry  : last bit shifted out (or wrapped for rotates); 0 when k == 0
module shift_step
  import iter_shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 2,
  localparam int K_W  = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [OP_W-1:0]  op,
  input  logic [K_W-1:0]   k,
  input  logic             sign,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH-1:0] ones;
  logic             left_c;
  logic             right_c;

  assign ones = '1;

  // The last bit to leave is data[WIDTH-k] going left and data[k-1] going
  // right; a constant-index loop avoids out-of-range selects when k == 0.
  always_comb begin
    // NOTE: every combinational output gets a default first, otherwise a
    // path that skips the assignment infers a latch.
    left_c  = 1'b0;
    right_c = 1'b0;
    for (int i = 1; i <= STEP; i++) begin
      if (int'(k) == i) begin
        left_c  = data[WIDTH-i];
        right_c = data[i-1];
      end
    end
  end

  always_comb begin
    result = data;
    carry  = 1'b0;
    case (op)
      OP_ROL: begin
        result = (data << k) | (data >> (WIDTH - int'(k)));
        carry  = left_c;
      end
      OP_ROR: begin
        result = (data >> k) | (data << (WIDTH - int'(k)));
        carry  = right_c;
      end
      OP_SLL: begin
        result = data << k;
        carry  = left_c;
      end
      OP_SRA: begin
        result = (data >> k) | ({WIDTH{sign}} & ~(ones >> k));
        carry  = right_c;
      end
      OP_SRL: begin
        result = data >> k;
        carry  = right_c;
      end
      default: begin
        result = data;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shifter/rotator, at most STEP positions per clock.
//   clk : rising-edge clock
//   rst : synchronous, active-low reset
//   bus : iter_shifter_if.slave (valid/ready request in, valid/ready result out)
// Parameters: WIDTH (power of 2, >= 4), STEP (power of 2, <= WIDTH).
// Optional: ITER_SHIFTER_STATUS_EN adds out_zero / out_carry status outputs.
// Flow: IDLE accepts a request; SHIFT applies min(rem, STEP) positions per edge;
// DONE holds the result until out_ready. Illegal ops and zero amounts skip SHIFT.
module iter_shifter
  import iter_shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 2
) (
  input logic          clk,
  input logic          rst,
  iter_shifter_if.slave bus
);

  localparam int AMT_W = $clog2(WIDTH);
  localparam int CNT_W = AMT_W + 1;
  localparam int K_W   = $clog2(STEP + 1);

  state_e           state;
  logic [WIDTH-1:0] acc;
  logic [AMT_W-1:0] rem;
  logic [OP_W-1:0]  op_q;
  logic             sign_q;
  logic             err_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [K_W-1:0]   step_k;
  logic [AMT_W-1:0] rem_next;
  logic [WIDTH-1:0] step_data;
  logic             step_carry;
  logic             accept;

  assign accept = (state == IDLE) && bus.in_valid;

  // Widen to CNT_W so STEP == WIDTH still compares correctly.
  always_comb begin
    step_k = K_W'(STEP);
    if ({1'b0, rem} < CNT_W'(STEP)) begin
      step_k = K_W'(rem);
    end
    rem_next = AMT_W'({1'b0, rem} - CNT_W'(step_k));
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data   (acc),
    .op     (op_q),
    .k      (step_k),
    .sign   (sign_q),
    .result (step_data),
    .carry  (step_carry)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      acc         <= '0;
      rem         <= '0;
      op_q        <= OP_ROL;
      sign_q      <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc        <= bus.in_data;
            rem        <= bus.in_amt;
            op_q       <= bus.in_op;
            sign_q     <= bus.in_data[WIDTH-1];
            in_ready_q <= 1'b0;
            if (!op_legal(bus.in_op) || (bus.in_amt == '0)) begin
              state       <= DONE;
              err_q       <= !op_legal(bus.in_op);
              out_valid_q <= 1'b1;
            end else begin
              state <= SHIFT;
              err_q <= 1'b0;
            end
          end
        end
        SHIFT: begin
          acc <= step_data;
          rem <= rem_next;
          if (rem_next == '0) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = acc;
  assign bus.out_err   = err_q;

`ifdef ITER_SHIFTER_STATUS_EN
  logic carry_q;

  // Cleared on accept, so zero amounts and illegal ops report carry 0;
  // SHIFT edges always move k >= 1 positions, so each overwrites it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      carry_q <= 1'b0;
    end else if (accept) begin
      carry_q <= 1'b0;
    end else if (state == SHIFT) begin
      carry_q <= step_carry;
    end
  end

  // Gated by out_valid so the flag reads 0 out of reset (acc == 0 then).
  assign bus.out_zero  = out_valid_q && (acc == '0);
  assign bus.out_carry = carry_q;
`else
  logic unused_carry;
  assign unused_carry = step_carry;
`endif

endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: directed self-checking bench for iter_shifter (WIDTH=16, STEP=2).
// Define ITER_SHIFTER_STATUS_EN for both RTL and bench to also check out_zero/out_carry.
module tb_iter_shifter;
  import iter_shifter_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  iter_shifter_if #(.WIDTH(16)) bus ();

  iter_shifter #(
    .WIDTH (16),
    .STEP  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One request: drive, accept, scramble inputs, wait for the result,
  // optionally stall the consumer for `hold` cycles, then release it.
  task automatic run_op(input string name, input logic [2:0] op, input logic [15:0] data,
                        input logic [3:0] amt, input logic [15:0] exp_data, input logic exp_err,
                        input int exp_lat, input logic exp_carry, input int hold);
    int lat;
    @(negedge clk);
    check({name, ".in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_amt   = amt;
    bus.in_op    = op;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = ~data;
    bus.in_amt   = ~amt;
    bus.in_op    = 3'b000;
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, ".latency"}, 32'(lat), 32'(exp_lat));
    check({name, ".data"}, 32'(bus.out_data), 32'(exp_data));
    check({name, ".err"}, 32'(bus.out_err), 32'(exp_err));
    check({name, ".in_ready_busy"}, 32'(bus.in_ready), 32'd0);
`ifdef ITER_SHIFTER_STATUS_EN
    check({name, ".carry"}, 32'(bus.out_carry), 32'(exp_carry));
    check({name, ".zero"}, 32'(bus.out_zero), 32'(exp_data == 16'h0000));
`else
    if (exp_carry === 1'bx) $display("note: carry unused");
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({name, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({name, ".hold_data"}, 32'(bus.out_data), 32'(exp_data));
      check({name, ".hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({name, ".valid_drop"}, 32'(bus.out_valid), 32'd0);
    check({name, ".ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    tests         = 0;
    failed        = 0;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.in_ready", 32'(bus.in_ready), 32'd1);
    check("reset.out_valid", 32'(bus.out_valid), 32'd0);
    check("reset.out_data", 32'(bus.out_data), 32'd0);
    check("reset.out_err", 32'(bus.out_err), 32'd0);
`ifdef ITER_SHIFTER_STATUS_EN
    check("reset.out_zero", 32'(bus.out_zero), 32'd0);
    check("reset.out_carry", 32'(bus.out_carry), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    //      name        op       data      amt    expected  err   lat carry hold
    run_op("rol1",     OP_ROL, 16'h8001, 4'd1,  16'h0003, 1'b0, 2, 1'b1, 0);
    run_op("sra5",     OP_SRA, 16'h8000, 4'd5,  16'hFC00, 1'b0, 4, 1'b0, 3);
    run_op("srl15",    OP_SRL, 16'h8000, 4'd15, 16'h0001, 1'b0, 9, 1'b0, 0);
    run_op("ror15",    OP_ROR, 16'h0001, 4'd15, 16'h0002, 1'b0, 9, 1'b0, 0);
    run_op("sll0",     OP_SLL, 16'h1234, 4'd0,  16'h1234, 1'b0, 1, 1'b0, 0);
    run_op("illegal6", 3'b110, 16'hBEEF, 4'd3,  16'hBEEF, 1'b1, 1, 1'b0, 0);
    run_op("sll12",    OP_SLL, 16'h00F0, 4'd12, 16'h0000, 1'b0, 7, 1'b1, 0);
    run_op("srl3",     OP_SRL, 16'h00FF, 4'd3,  16'h001F, 1'b0, 3, 1'b1, 0);
    run_op("rol4",     OP_ROL, 16'h1234, 4'd4,  16'h2341, 1'b0, 3, 1'b1, 0);
    run_op("sra4pos",  OP_SRA, 16'h7FF0, 4'd4,  16'h07FF, 1'b0, 3, 1'b0, 0);
    run_op("illegal7", 3'b111, 16'h5555, 4'd0,  16'h5555, 1'b1, 1, 1'b0, 0);

    // Reset in the middle of SHIFT discards the operation.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h8000;
    bus.in_amt   = 4'd9;
    bus.in_op    = OP_SRA;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midreset.in_ready", 32'(bus.in_ready), 32'd1);
    check("midreset.out_valid", 32'(bus.out_valid), 32'd0);
    check("midreset.out_data", 32'(bus.out_data), 32'd0);
    check("midreset.out_err", 32'(bus.out_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      check("midreset.no_output", 32'(bus.out_valid), 32'd0);
    end
    run_op("after_rst", OP_ROR, 16'h00F1, 4'd4, 16'h100F, 1'b0, 3, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
